// File: rtl/tt_uio_pattern_tester.sv
// -----------------------------------------------------------------------------
// tt_uio_pattern_tester
//
// Purpose:
//   Programmable driver and loopback checker for the uio pad bank. When it is
//   idle, or when mode is off, it behaves like the plain all-inputs tie-off
//   (uio_out=0, uio_oe=0). When it is started, it drives a pattern under a
//   per-bit output-enable mask. The pattern is a counter, a walking one or an
//   LFSR, and it advances once per prescaler period. At each step the returning
//   uio_in is compared with the pattern being driven, and mismatches are
//   counted in a saturating counter.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   ena_i      0 = pause (prescaler, pattern and checker frozen)
//   run_i      level: 1 = generate/check, 0 = return to idle (beats ena_i)
//   mode_i     00 off, 01 counter, 10 walking-one, 11 LFSR (latched at start)
//   div_i      prescaler reload; one step every div+1 enabled clocks (latched)
//   oe_mask_i  bits to drive and to check (latched)
//   uio_in_i   pad input path (loopback)
//   uio_out_o  registered pattern
//   uio_oe_o   registered output enable
//   err_cnt_o  saturating mismatch count
//   busy_o     1 while running or paused
//   match_o    result of the most recent compare (1 = no mismatch)
// -----------------------------------------------------------------------------
module tt_uio_pattern_tester #(
  parameter int               WIDTH     = 8,
  parameter int               DIV_W     = 4,
  parameter int               ERR_W     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  input  logic             run_i,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [WIDTH-1:0] oe_mask_i,
  input  logic [WIDTH-1:0] uio_in_i,
  output logic [WIDTH-1:0] uio_out_o,
  output logic [WIDTH-1:0] uio_oe_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             busy_o,
  output logic             match_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_CNT  = 2'b01;
  localparam logic [1:0] MODE_WALK = 2'b10;
  localparam logic [1:0] MODE_LFSR = 2'b11;

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic [WIDTH-1:0] mask_q;
  logic [DIV_W-1:0] presc_q;
  logic [WIDTH-1:0] uio_out_q;
  logic [WIDTH-1:0] uio_oe_q;
  logic [ERR_W-1:0] err_q;
  logic             busy_q;
  logic             match_q;

  logic [WIDTH-1:0] seed_d;
  logic [WIDTH-1:0] step_d;
  logic [WIDTH-1:0] diff_bits_d;
  logic             mismatch_d;
  logic             tick_d;
  logic             check_en_d;

  // Seed depends on the requested mode, because it is loaded on the start edge.
  always_comb begin
    seed_d = {{(WIDTH-1){1'b0}}, 1'b1};
    if (mode_i == MODE_CNT) seed_d = '0;
  end

  // Next pattern, chosen by the latched mode.
  always_comb begin
    step_d = uio_out_q;
    case (mode_q)
      MODE_CNT:  step_d = uio_out_q + {{(WIDTH-1){1'b0}}, 1'b1};
      MODE_WALK: step_d = {uio_out_q[WIDTH-2:0], uio_out_q[WIDTH-1]};
      MODE_LFSR: step_d = (uio_out_q >> 1) ^ (uio_out_q[0] ? LFSR_TAPS : '0);
      default:   step_d = uio_out_q;
    endcase
  end

  // Per-bit loopback compare. Bits outside the mask are ignored.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cmp
    assign diff_bits_d[gi] = (uio_in_i[gi] ^ uio_out_q[gi]) & mask_q[gi];
  end
  assign mismatch_d = |diff_bits_d;

  assign tick_d = (presc_q == '0);
  // With div 0 or 1 the pads get too little settle time, so checking is skipped.
  assign check_en_d = (div_q > {{(DIV_W-1){1'b0}}, 1'b1});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_OFF;
      div_q     <= '0;
      mask_q    <= '0;
      presc_q   <= '0;
      uio_out_q <= '0;
      uio_oe_q  <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      match_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // mode 00 keeps the block in the legacy tie-off state.
          if (run_i && (mode_i != MODE_OFF)) begin
            state_q   <= ST_RUN;
            mode_q    <= mode_i;
            div_q     <= div_i;
            mask_q    <= oe_mask_i;
            presc_q   <= div_i;
            uio_out_q <= seed_d;
            uio_oe_q  <= oe_mask_i;
            err_q     <= '0;
            busy_q    <= 1'b1;
            match_q   <= 1'b1;
          end
        end

        ST_RUN, ST_PAUSE: begin
          if (!run_i) begin
            // err_q and match_q are kept so the result can be read after the run.
            state_q   <= ST_IDLE;
            uio_out_q <= '0;
            uio_oe_q  <= '0;
            busy_q    <= 1'b0;
          end else if (!ena_i) begin
            state_q <= ST_PAUSE;
          end else begin
            // An enabled clock counts whether the previous cycle was paused or
            // not, so a pause only removes cycles and never shifts a step.
            state_q <= ST_RUN;
            if (tick_d) begin
              presc_q   <= div_q;
              uio_out_q <= step_d;
              if (check_en_d) begin
                match_q <= !mismatch_d;
                if (mismatch_d && (err_q != {ERR_W{1'b1}})) begin
                  err_q <= err_q + {{(ERR_W-1){1'b0}}, 1'b1};
                end
              end
            end else begin
              presc_q <= presc_q - {{(DIV_W-1){1'b0}}, 1'b1};
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign uio_out_o = uio_out_q;
  assign uio_oe_o  = uio_oe_q;
  assign err_cnt_o = err_q;
  assign busy_o    = busy_q;
  assign match_o   = match_q;

endmodule

// File: tb/tb_tt_uio_pattern_tester.sv
// -----------------------------------------------------------------------------
// tb_tt_uio_pattern_tester
//
// Self-checking bench for tt_uio_pattern_tester. Inputs are driven on the
// falling edge and outputs are compared on the following falling edge.
//
// uio_in is looped back as (uio_out & and_m) ^ xor_m, so the bench can plant
// stuck-at and flipped bits.
//
// The reference model counts enabled clocks and steps, then derives the
// expected pattern from the step index. It does not use the DUT's
// prescaler or its state encoding.
// -----------------------------------------------------------------------------
module tb_tt_uio_pattern_tester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       run;
  logic [1:0] mode;
  logic [3:0] div;
  logic [7:0] oe_mask;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] err_count;
  logic       busy;
  logic       match;

  logic [7:0] and_m;
  logic [7:0] xor_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign uio_in = (uio_out & and_m) ^ xor_m;

  tt_uio_pattern_tester #(
    .WIDTH(8), .DIV_W(4), .ERR_W(8), .LFSR_TAPS(8'hB8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena_i     (ena),
    .run_i     (run),
    .mode_i    (mode),
    .div_i     (div),
    .oe_mask_i (oe_mask),
    .uio_in_i  (uio_in),
    .uio_out_o (uio_out),
    .uio_oe_o  (uio_oe),
    .err_cnt_o (err_count),
    .busy_o    (busy),
    .match_o   (match)
  );

  // ---------------- reference model ----------------
  bit         m_active;
  logic [1:0] m_mode;
  int         m_div;
  logic [7:0] m_mask;
  int         m_cnt;
  int         m_steps;
  int         m_err;
  bit         m_match;

  // Pattern after n steps, computed directly from the step index.
  function automatic logic [7:0] pattern_at(input logic [1:0] md, input int n);
    logic [7:0] p;
    case (md)
      2'b01: return 8'(n % 256);
      2'b10: return 8'(1 << (n % 8));
      2'b11: begin
        p = 8'h01;
        for (int i = 0; i < (n % 255); i++) p = (p >> 1) ^ (p[0] ? 8'hB8 : 8'h00);
        return p;
      end
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0; m_mode = 2'b00; m_div = 0; m_mask = 8'h00;
    m_cnt = 0; m_steps = 0; m_err = 0; m_match = 1;
  endtask

  // Applies the effect of the coming rising edge, using the current inputs.
  task automatic model_step();
    logic [7:0] p;
    logic [7:0] pin;
    bit         mm;
    if (!m_active) begin
      if (run && mode != 2'b00) begin
        m_active = 1; m_mode = mode; m_div = int'(div); m_mask = oe_mask;
        m_cnt = 0; m_steps = 0; m_err = 0; m_match = 1;
      end
    end else if (!run) begin
      m_active = 0;
    end else if (ena) begin
      m_cnt++;
      if (m_cnt % (m_div + 1) == 0) begin
        if (m_div >= 2) begin
          p   = pattern_at(m_mode, m_steps);
          pin = (p & and_m) ^ xor_m;
          mm  = ((p ^ pin) & m_mask) != 8'h00;
          m_match = !mm;
          if (mm && m_err < 255) m_err++;
        end
        m_steps++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("uio_out", 32'(uio_out), m_active ? 32'(pattern_at(m_mode, m_steps)) : 32'h0);
    chk("uio_oe", 32'(uio_oe), m_active ? 32'(m_mask) : 32'h0);
    chk("busy", 32'(busy), 32'(m_active));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("match", 32'(match), 32'(m_match));
  endtask

  // Call with inputs set at a falling edge. It covers one rising edge and then
  // compares at the next falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic restart(input logic [1:0] md, input logic [3:0] dv, input logic [7:0] mk);
    run = 1'b0; ena = 1'b1;
    cycle();
    mode = md; div = dv; oe_mask = mk; run = 1'b1;
    cycle();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out"}, 32'(uio_out), 32'h0);
    chk({tag, "_oe"}, 32'(uio_oe), 32'h0);
    chk({tag, "_err"}, 32'(err_count), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_match"}, 32'(match), 32'h1);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [3:0] div;
    int         n;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[15];

  logic [7:0] held;

  initial begin
    // Expected patterns, with n counted as steps after the start edge.
    vecs[0]  = '{2'b01, 4'd3, 0,   8'h00};
    vecs[1]  = '{2'b01, 4'd3, 1,   8'h01};
    vecs[2]  = '{2'b01, 4'd3, 2,   8'h02};
    vecs[3]  = '{2'b01, 4'd3, 255, 8'hFF};
    vecs[4]  = '{2'b01, 4'd3, 256, 8'h00};
    vecs[5]  = '{2'b10, 4'd2, 1,   8'h02};
    vecs[6]  = '{2'b10, 4'd2, 7,   8'h80};
    vecs[7]  = '{2'b10, 4'd2, 8,   8'h01};
    vecs[8]  = '{2'b11, 4'd0, 0,   8'h01};
    vecs[9]  = '{2'b11, 4'd0, 1,   8'hB8};
    vecs[10] = '{2'b11, 4'd0, 2,   8'h5C};
    vecs[11] = '{2'b11, 4'd0, 3,   8'h2E};
    vecs[12] = '{2'b11, 4'd0, 4,   8'h17};
    vecs[13] = '{2'b11, 4'd0, 5,   8'hB3};
    vecs[14] = '{2'b11, 4'd0, 255, 8'h01};

    rst_n = 1'b0; ena = 1'b1; run = 1'b0; mode = 2'b00; div = 4'd0; oe_mask = 8'h00;
    and_m = 8'hFF; xor_m = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("por");
    $display("reset: out=%0h oe=%0h err=%0h busy=%0b match=%0b", uio_out, uio_oe, err_count, busy, match);
    rst_n = 1'b1;

    // Mid-run reset: outputs clear at once, then the block restarts after release.
    mode = 2'b01; div = 4'd3; oe_mask = 8'hFF; run = 1'b1;
    repeat (7) cycle();
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("rst_reenter_busy", 32'(busy), 32'h1);
    $display("mid-run reset: re-entered busy=%0b out=%0h oe=%0h", busy, uio_out, uio_oe);

    // Check the table of expected patterns.
    for (int v = 0; v < 15; v++) begin
      restart(vecs[v].mode, vecs[v].div, 8'hFF);
      repeat (vecs[v].n * (int'(vecs[v].div) + 1)) cycle();
      chk("vec_out", 32'(uio_out), 32'(vecs[v].exp));
      chk("vec_err", 32'(err_count), 32'h0);
      $display("vec %0d: mode=%0d div=%0d n=%0d out=%0h exp=%0h", v, vecs[v].mode, vecs[v].div,
               vecs[v].n, uio_out, vecs[v].exp);
    end

    // Mode 00 keeps the block in the tie-off state.
    restart(2'b00, 4'd0, 8'hFF);
    repeat (3) cycle();
    chk("off_busy", 32'(busy), 32'h0);
    chk("off_oe", 32'(uio_oe), 32'h0);
    $display("mode off: busy=%0b oe=%0h", busy, uio_oe);

    // Changing the config inputs mid-run has no effect.
    restart(2'b10, 4'd2, 8'hFF);
    repeat (9) cycle();
    chk("walk_idx3", 32'(uio_out), 32'h08);
    mode = 2'b11; oe_mask = 8'h00; div = 4'd0;
    repeat (3) cycle();
    chk("walk_after_modechg", 32'(uio_out), 32'h10);
    chk("oe_after_maskchg", 32'(uio_oe), 32'hFF);
    $display("mid-run cfg change: out=%0h oe=%0h", uio_out, uio_oe);

    // uio_in[3] stuck at 0: over 40 compared steps (0..39) bit 3 is set 16 times.
    and_m = 8'hF7;
    restart(2'b01, 4'd2, 8'hFF);
    repeat (40 * 3) cycle();
    chk("stuck_err", 32'(err_count), 32'd16);
    chk("stuck_match", 32'(match), 32'h1);
    $display("stuck bit3 mask=FF: err=%0d match=%0b", err_count, match);
    restart(2'b01, 4'd2, 8'hF7);
    repeat (40 * 3) cycle();
    chk("masked_err", 32'(err_count), 32'd0);
    $display("stuck bit3 mask=F7: err=%0d", err_count);

    // Saturation.
    and_m = 8'hFF; xor_m = 8'hFF;
    restart(2'b01, 4'd2, 8'hFF);
    repeat (300 * 3) cycle();
    chk("sat_err", 32'(err_count), 32'hFF);
    chk("sat_match", 32'(match), 32'h0);
    $display("saturation: err=%0h match=%0b", err_count, match);
    xor_m = 8'h00;

    // Pause in the middle of a step, then run=0 while paused.
    restart(2'b01, 4'd3, 8'hFF);
    repeat (6) cycle();
    held = uio_out;
    ena = 1'b0;
    repeat (10) cycle();
    chk("pause_out", 32'(uio_out), 32'(held));
    chk("pause_busy", 32'(busy), 32'h1);
    ena = 1'b1;
    repeat (2) cycle();
    chk("resume_step", 32'(uio_out), 32'h02);
    ena = 1'b0;
    cycle();
    run = 1'b0;
    cycle();
    chk("paused_stop_oe", 32'(uio_oe), 32'h0);
    chk("paused_stop_busy", 32'(busy), 32'h0);
    $display("pause: held=%0h resumed, stop while paused oe=%0h busy=%0b", held, uio_oe, busy);

    // Random trials, checked against the model.
    for (int t = 0; t < 20; t++) begin
      int ncyc;
      and_m = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      xor_m = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom);
      restart(2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)), 8'($urandom));
      ncyc = int'($urandom_range(50, 300));
      for (int c = 0; c < ncyc; c++) begin
        ena = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0) begin
          mode = 2'($urandom); div = 4'($urandom); oe_mask = 8'($urandom);
        end
        cycle();
      end
      ena = 1'b1; run = 1'b0;
      cycle();
      $display("rand %0d: mode=%0d div=%0d mask=%0h cycles=%0d err=%0d match=%0b",
               t, m_mode, m_div, m_mask, ncyc, err_count, match);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
